// File: rtl/pipe_stage_register.sv
// Purpose : one Y86-64 pipe stage register (default placement: memory -> writeback) with
//           bubble injection, memory-error status override, sticky exception freeze and event counters.
// Latency : one cycle; backpressure via stall (hold), which a sticky freeze overrides.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset (highest priority)
//   stall, bubble         hold contents / load a NOP bubble (stall wins when both are set)
//   in_valid, in_status   upstream instruction-present flag and status
//   mem_error             memory access fault for the upstream instruction (forces STAT_ADR)
//   in_icode, in_dste, in_dstm, in_vale, in_valm   upstream payload
//   out_*                 registered payload, valid and status
//   frozen                set by a valid instruction with non-AOK status; cleared only by reset
//   retire_count          saturating count of loads carrying a valid instruction
//   stall_count           saturating count of stalled cycles while not frozen
module pipe_stage_register #(
    parameter int DATA_W    = 64,
    parameter int ICODE_W   = 4,
    parameter int REG_W     = 4,
    parameter int STAT_W    = 2,
    parameter int CNT_W     = 32,
    parameter int NOP_ICODE = 1,
    parameter int RNONE     = 15,
    parameter int STAT_AOK  = 0,
    parameter int STAT_ADR  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                bubble,
    input  logic                in_valid,
    input  logic [STAT_W-1:0]   in_status,
    input  logic                mem_error,
    input  logic [ICODE_W-1:0]  in_icode,
    input  logic [REG_W-1:0]    in_dste,
    input  logic [REG_W-1:0]    in_dstm,
    input  logic [DATA_W-1:0]   in_vale,
    input  logic [DATA_W-1:0]   in_valm,
    output logic                out_valid,
    output logic [STAT_W-1:0]   out_status,
    output logic [ICODE_W-1:0]  out_icode,
    output logic [REG_W-1:0]    out_dste,
    output logic [REG_W-1:0]    out_dstm,
    output logic [DATA_W-1:0]   out_vale,
    output logic [DATA_W-1:0]   out_valm,
    output logic                frozen,
    output logic [CNT_W-1:0]    retire_count,
    output logic [CNT_W-1:0]    stall_count
);

    localparam logic [STAT_W-1:0]  AOK      = STAT_W'(STAT_AOK);
    localparam logic [STAT_W-1:0]  ADR      = STAT_W'(STAT_ADR);
    localparam logic [ICODE_W-1:0] NOP_CODE = ICODE_W'(NOP_ICODE);
    localparam logic [REG_W-1:0]   NO_REG   = REG_W'(RNONE);

    typedef struct packed {
        logic                valid;
        logic [STAT_W-1:0]   status;
        logic [ICODE_W-1:0]  icode;
        logic [REG_W-1:0]    dste;
        logic [REG_W-1:0]    dstm;
        logic [DATA_W-1:0]   vale;
        logic [DATA_W-1:0]   valm;
    } stage_t;

    // Reset and bubble load the same empty slot.
    localparam stage_t EMPTY_STAGE = '{
        valid:  1'b0,
        status: AOK,
        icode:  NOP_CODE,
        dste:   NO_REG,
        dstm:   NO_REG,
        vale:   '0,
        valm:   '0
    };

    stage_t             stage_q;
    stage_t             stage_d;
    stage_t             load_val;
    logic               frozen_q;
    logic               frozen_d;
    logic [CNT_W-1:0]   retire_q;
    logic [CNT_W-1:0]   retire_d;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   stall_d;
    logic [STAT_W-1:0]  eff_status;
    logic               do_load;
    logic               retire_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The memory-error override only applies to a real instruction; an empty
    // slot passes its status through untouched.
    always_comb begin
        eff_status = (in_valid && mem_error) ? ADR : in_status;
        load_val   = '{
            valid:  in_valid,
            status: eff_status,
            icode:  in_icode,
            dste:   in_dste,
            dstm:   in_dstm,
            vale:   in_vale,
            valm:   in_valm
        };
    end

    always_comb begin
        do_load    = !frozen_q && !stall && !bubble;
        retire_evt = do_load && in_valid;

        stage_d = stage_q;
        if (!frozen_q && !stall) begin
            stage_d = bubble ? EMPTY_STAGE : load_val;
        end

        // The faulting instruction is captured and frozen on the same edge.
        frozen_d = frozen_q || (retire_evt && (eff_status != AOK));
        retire_d = retire_evt ? sat_inc(retire_q) : retire_q;
        stall_d  = (!frozen_q && stall) ? sat_inc(stall_q) : stall_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q  <= EMPTY_STAGE;
            frozen_q <= 1'b0;
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            stage_q  <= stage_d;
            frozen_q <= frozen_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign out_valid    = stage_q.valid;
    assign out_status   = stage_q.status;
    assign out_icode    = stage_q.icode;
    assign out_dste     = stage_q.dste;
    assign out_dstm     = stage_q.dstm;
    assign out_vale     = stage_q.vale;
    assign out_valm     = stage_q.valm;
    assign frozen       = frozen_q;
    assign retire_count = retire_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_pipe_stage_register.sv
// Purpose : directed bench for pipe_stage_register, default widths and a narrow (32-bit data, 3-bit counter) copy.
// Latency : outputs compared every negedge against a rule-level model updated at posedge.
// Backpressure: stall/bubble/freeze sequences driven directly; no handshakes to wait on.
module tb_pipe_stage_register;

    logic        clock = 1'b0;
    logic        reset, stall, bubble, in_valid, mem_error;
    logic [1:0]  in_status;
    logic [3:0]  in_icode, in_dste, in_dstm;
    logic [63:0] in_vale, in_valm;

    logic        a_valid, b_valid, a_frozen, b_frozen;
    logic [1:0]  a_status, b_status;
    logic [3:0]  a_icode, b_icode, a_dste, b_dste, a_dstm, b_dstm;
    logic [63:0] a_vale, a_valm;
    logic [31:0] b_vale, b_valm;
    logic [31:0] a_retire, a_stall;
    logic [2:0]  b_retire, b_stall;

    always #5 clock = ~clock;

    pipe_stage_register dut_a (
        .clock(clock), .reset(reset), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_status(in_status), .mem_error(mem_error),
        .in_icode(in_icode), .in_dste(in_dste), .in_dstm(in_dstm),
        .in_vale(in_vale), .in_valm(in_valm),
        .out_valid(a_valid), .out_status(a_status), .out_icode(a_icode),
        .out_dste(a_dste), .out_dstm(a_dstm), .out_vale(a_vale), .out_valm(a_valm),
        .frozen(a_frozen), .retire_count(a_retire), .stall_count(a_stall)
    );

    pipe_stage_register #(.DATA_W(32), .CNT_W(3)) dut_b (
        .clock(clock), .reset(reset), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_status(in_status), .mem_error(mem_error),
        .in_icode(in_icode), .in_dste(in_dste), .in_dstm(in_dstm),
        .in_vale(in_vale[31:0]), .in_valm(in_valm[31:0]),
        .out_valid(b_valid), .out_status(b_status), .out_icode(b_icode),
        .out_dste(b_dste), .out_dstm(b_dstm), .out_vale(b_vale), .out_valm(b_valm),
        .frozen(b_frozen), .retire_count(b_retire), .stall_count(b_stall)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: index 0 = default instance, 1 = narrow instance.
    longint m_valid[2], m_status[2], m_icode[2], m_dste[2], m_dstm[2];
    longint m_vale[2], m_valm[2], m_frozen[2], m_retire[2], m_stall[2];
    longint dmask[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    longint cmax[2]  = '{64'h0000_0000_FFFF_FFFF, 64'd7};
    logic   chk_en   = 1'b0;

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            longint st;
            st = (in_valid && mem_error) ? 2 : longint'(in_status);
            if (reset || (!m_frozen[k] && !stall && bubble)) begin
                m_valid[k] <= 0; m_status[k] <= 0; m_icode[k] <= 1;
                m_dste[k]  <= 15; m_dstm[k]  <= 15; m_vale[k] <= 0; m_valm[k] <= 0;
            end
            if (reset) begin
                m_frozen[k] <= 0; m_retire[k] <= 0; m_stall[k] <= 0;
            end else if (m_frozen[k]) begin
                // everything holds
            end else if (stall) begin
                if (m_stall[k] < cmax[k]) m_stall[k] <= m_stall[k] + 1;
            end else if (!bubble) begin
                m_valid[k] <= longint'(in_valid); m_status[k] <= st;
                m_icode[k] <= longint'(in_icode);
                m_dste[k]  <= longint'(in_dste);  m_dstm[k] <= longint'(in_dstm);
                m_vale[k]  <= in_vale & dmask[k]; m_valm[k] <= in_valm & dmask[k];
                if (in_valid) begin
                    if (m_retire[k] < cmax[k]) m_retire[k] <= m_retire[k] + 1;
                    if (st != 0) m_frozen[k] <= 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("a_valid",  longint'(a_valid),  m_valid[0]);
            chk("a_status", longint'(a_status), m_status[0]);
            chk("a_icode",  longint'(a_icode),  m_icode[0]);
            chk("a_dste",   longint'(a_dste),   m_dste[0]);
            chk("a_dstm",   longint'(a_dstm),   m_dstm[0]);
            chk("a_vale",   a_vale,             m_vale[0]);
            chk("a_valm",   a_valm,             m_valm[0]);
            chk("a_frozen", longint'(a_frozen), m_frozen[0]);
            chk("a_retire", longint'(a_retire), m_retire[0]);
            chk("a_stall",  longint'(a_stall),  m_stall[0]);
            chk("b_valid",  longint'(b_valid),  m_valid[1]);
            chk("b_status", longint'(b_status), m_status[1]);
            chk("b_icode",  longint'(b_icode),  m_icode[1]);
            chk("b_dste",   longint'(b_dste),   m_dste[1]);
            chk("b_dstm",   longint'(b_dstm),   m_dstm[1]);
            chk("b_vale",   longint'(b_vale),   m_vale[1]);
            chk("b_valm",   longint'(b_valm),   m_valm[1]);
            chk("b_frozen", longint'(b_frozen), m_frozen[1]);
            chk("b_retire", longint'(b_retire), m_retire[1]);
            chk("b_stall",  longint'(b_stall),  m_stall[1]);
        end
    end

    task automatic idle();
        reset = 0; stall = 0; bubble = 0; in_valid = 0; mem_error = 0;
        in_status = 0; in_icode = 0; in_dste = 0; in_dstm = 0;
        in_vale = 0; in_valm = 0;
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic me,
                         input logic [3:0] ic, input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
        in_valid = v; in_status = st; mem_error = me; in_icode = ic;
        in_dste = de; in_dstm = dm; in_vale = ve; in_valm = vm;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        idle();
        reset = 1;
        cyc(2);
        chk_en = 1'b1;
        chk("rst_icode", longint'(a_icode), 1);
        chk("rst_dste", longint'(a_dste), 15);
        chk("rst_valid", longint'(a_valid), 0);
        chk("rst_retire", longint'(a_retire), 0);

        // First valid load.
        reset = 0;
        drive(1, 0, 0, 6, 3, 15, 64'h10, 64'h20);
        cyc(1);
        chk("load_icode", longint'(a_icode), 6);
        chk("load_vale", a_vale, 64'h10);
        chk("load_valid", longint'(a_valid), 1);
        chk("load_status", longint'(a_status), 0);
        chk("load_retire", longint'(a_retire), 1);

        // Three stalled cycles with moving inputs, then stall plus bubble.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 4'(2 + i), 4'(i), 4'(i), 64'(100 + i), 64'(200 + i));
            cyc(1);
        end
        chk("stall3_cnt", longint'(a_stall), 3);
        chk("stall3_icode", longint'(a_icode), 6);
        bubble = 1;
        cyc(1);
        chk("stallbub_cnt", longint'(a_stall), 4);
        chk("stallbub_vale", a_vale, 64'h10);

        // Valid load, then bubble.
        stall = 0; bubble = 0;
        drive(1, 0, 0, 3, 2, 5, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
        cyc(1);
        chk("wide_vale_b", longint'(b_vale), 64'h9ABC_DEF0);
        bubble = 1;
        cyc(1);
        chk("bub_icode", longint'(a_icode), 1);
        chk("bub_valm", a_valm, 0);
        chk("bub_valid", longint'(a_valid), 0);
        chk("bub_retire", longint'(a_retire), 2);

        // Empty slot: status passes through, no override, no freeze, no count.
        bubble = 0;
        drive(0, 3, 1, 9, 1, 1, 64'h55, 64'h66);
        cyc(1);
        chk("inv_status", longint'(a_status), 3);
        chk("inv_frozen", longint'(a_frozen), 0);

        // Memory error on a valid instruction: ADR status and freeze.
        drive(1, 0, 1, 5, 7, 8, 64'hAA, 64'hBB);
        cyc(1);
        chk("memerr_status", longint'(a_status), 2);
        chk("memerr_frozen", longint'(a_frozen), 1);
        chk("memerr_retire", longint'(a_retire), 3);
        drive(1, 0, 0, 2, 1, 1, 64'h77, 64'h88);
        cyc(1);
        bubble = 1;
        cyc(1);
        bubble = 0; stall = 1;
        cyc(1);
        chk("frz_icode", longint'(a_icode), 5);
        chk("frz_stall", longint'(a_stall), 4);
        stall = 0;
        reset = 1;
        cyc(1);
        chk("unfrz_frozen", longint'(a_frozen), 0);
        chk("unfrz_icode", longint'(a_icode), 1);

        // Reset while stalled.
        reset = 0;
        drive(1, 0, 0, 6, 4, 4, 64'h42, 64'h43);
        cyc(1);
        stall = 1;
        cyc(2);
        reset = 1;
        cyc(1);
        chk("rststall_stall", longint'(a_stall), 0);
        chk("rststall_retire", longint'(a_retire), 0);
        chk("rststall_valid", longint'(a_valid), 0);

        // Nine valid loads: narrow counter saturates at 7.
        reset = 0; stall = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 7, 4'(i), 4'(15 - i),
                  {32'hC0DE_0000 | 32'(i), 32'hA5A5_0000 | 32'(i)},
                  {32'h1111_1111, 32'(i * 3)});
            cyc(1);
        end
        chk("sat_b_retire", longint'(b_retire), 7);
        chk("sat_a_retire", longint'(a_retire), 9);
        chk("sat_b_vale", longint'(b_vale), 64'hA5A5_0008);
        chk("sat_a_vale", a_vale, 64'hC0DE_0008_A5A5_0008);

        // Non-AOK upstream status on a valid instruction also freezes.
        drive(1, 3, 0, 4, 2, 2, 64'h9, 64'h9);
        cyc(1);
        chk("stat_frozen", longint'(a_frozen), 1);
        chk("stat_status", longint'(a_status), 3);
        idle();
        cyc(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
